// File: rtl/bp_pkg.sv
// ---------------------------------------------------------------------------
// bp_pkg
//   Shared types and constants for the branch redirect stage.
//
//   bp_entry_t  : prediction carried down the F->D->E pipeline alongside an
//                 instruction {valid, pred_taken, pred_tgt}.
//   btb_entry_t : one branch target buffer line as seen by a lookup.
//                 The tag is zero-extended to 32 bits so the type does not
//                 depend on the BTB size parameter.
//   PC_STEP     : sequential fetch increment in bytes.
// ---------------------------------------------------------------------------
package bp_pkg;

    localparam int PC_STEP = 4;

    typedef struct packed {
        logic        valid;
        logic        pred_taken;
        logic [31:0] pred_tgt;
    } bp_entry_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] tag;
        logic [31:0] target;
    } btb_entry_t;

endpackage

// File: rtl/btb_dm.sv
// ---------------------------------------------------------------------------
// btb_dm
//   Direct-mapped branch target buffer. Asynchronous read, synchronous write.
//   Only the valid bits are reset; tag/target contents are don't-care while
//   their valid bit is clear.
//
//   Ports:
//     clk     in   rising-edge clock
//     reset   in   asynchronous, active-low; clears every valid bit
//     rd_pc   in   lookup PC (index = rd_pc[MEM_SIZE+1:2])
//     hit     out  entry valid and tag matches rd_pc[31:MEM_SIZE+2]
//     rd_tgt  out  stored target of the indexed entry
//     we      in   write enable
//     wr_pc   in   PC of the branch being recorded
//     wr_tgt  in   taken target of that branch
//
//   A write and a read to the same index in one cycle: the read sees the
//   contents from before the write, since the array only changes at the edge.
// ---------------------------------------------------------------------------
module btb_dm
    import bp_pkg::*;
#(
    parameter int MEM_SIZE = 4,
    parameter int TAG_W    = 32 - MEM_SIZE - 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] rd_pc,
    output logic        hit,
    output logic [31:0] rd_tgt,
    input  logic        we,
    input  logic [31:0] wr_pc,
    input  logic [31:0] wr_tgt
);

    localparam int DEPTH = 1 << MEM_SIZE;

    logic [DEPTH-1:0]    valid_q;
    logic [TAG_W-1:0]    tag_q [DEPTH];
    logic [31:0]         tgt_q [DEPTH];

    logic [MEM_SIZE-1:0] rd_idx;
    logic [MEM_SIZE-1:0] wr_idx;
    logic [TAG_W-1:0]    rd_tag;
    btb_entry_t          rd_entry;

    // Instruction PCs are word aligned; the byte-offset bits carry no information.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{rd_pc[1:0], wr_pc[1:0]};

    assign rd_idx = rd_pc[MEM_SIZE+1:2];
    assign wr_idx = wr_pc[MEM_SIZE+1:2];
    assign rd_tag = rd_pc[31:MEM_SIZE+2];

    assign rd_entry = '{
        valid:  valid_q[rd_idx],
        tag:    {{(32-TAG_W){1'b0}}, tag_q[rd_idx]},
        target: tgt_q[rd_idx]
    };

    assign hit    = rd_entry.valid && (rd_entry.tag == {{(32-TAG_W){1'b0}}, rd_tag});
    assign rd_tgt = rd_entry.target;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
        end else if (we) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    // Payload has no reset: it is only observed through a set valid bit.
    always_ff @(posedge clk) begin
        if (we) begin
            tag_q[wr_idx] <= wr_pc[31:MEM_SIZE+2];
            tgt_q[wr_idx] <= wr_tgt;
        end
    end

endmodule

// File: rtl/bp_redirect_unit.sv
// ---------------------------------------------------------------------------
// bp_redirect_unit
//   Next-PC selection and misprediction recovery around the 2-bit counter
//   predictor (BPU_2). The predictor's direction (BP) is only trusted when
//   the BTB also knows a target for PCF. The prediction rides with the
//   instruction to Execute, where it is checked against the resolved branch.
//
//   Ports:
//     clk, reset        clock; asynchronous active-low reset
//     BP                predictor direction for PCF (1 = taken)
//     PCF               current fetch PC
//     StallF, StallD    hazard unit stalls for F capture / D register
//     FlushE            hazard unit bubble into E
//     BranchE, ZeroE    E-stage branch flag and condition (taken = both)
//     PCE, PCTargetE    E-stage PC and computed branch target
//     PCNextF           next fetch PC
//     MispredictE       one-cycle redirect; hazard unit flushes D and E
//     BranchB/ZeroB/PCB predictor update port (resolved branch, outcome, PC)
//     BrCount           resolved branches, saturating
//     MissCount         mispredictions, saturating
// ---------------------------------------------------------------------------
module bp_redirect_unit
    import bp_pkg::*;
#(
    parameter int MEM_SIZE = 4,
    parameter int TAG_W    = 32 - MEM_SIZE - 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        BP,
    input  logic [31:0] PCF,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushE,
    input  logic        BranchE,
    input  logic        ZeroE,
    input  logic [31:0] PCE,
    input  logic [31:0] PCTargetE,
    output logic [31:0] PCNextF,
    output logic        MispredictE,
    output logic        BranchB,
    output logic        ZeroB,
    output logic [31:0] PCB,
    output logic [31:0] BrCount,
    output logic [31:0] MissCount
);

    localparam logic [31:0] STEP    = 32'(PC_STEP);
    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

    // ---------------- fetch-side lookup ----------------
    logic        btb_hit_f;
    logic [31:0] btb_tgt_f;
    logic        pred_taken_f;

    // ---------------- prediction pipeline ----------------
    bp_entry_t d_q;
    bp_entry_t e_q;

    // ---------------- execute-side resolution ----------------
    logic resolve_e;
    logic actual_taken_e;
    logic miss_e;
    logic btb_we;

    btb_dm #(
        .MEM_SIZE (MEM_SIZE),
        .TAG_W    (TAG_W)
    ) u_btb (
        .clk    (clk),
        .reset  (reset),
        .rd_pc  (PCF),
        .hit    (btb_hit_f),
        .rd_tgt (btb_tgt_f),
        .we     (btb_we),
        .wr_pc  (PCE),
        .wr_tgt (PCTargetE)
    );

    // A taken direction without a known target cannot be followed.
    assign pred_taken_f = BP & btb_hit_f;

    assign resolve_e      = e_q.valid & BranchE;
    assign actual_taken_e = BranchE & ZeroE;

    // Wrong direction, or right direction (taken) but stale target.
    always_comb begin
        miss_e = 1'b0;
        if (resolve_e) begin
            if (actual_taken_e != e_q.pred_taken) begin
                miss_e = 1'b1;
            end else if (actual_taken_e && (e_q.pred_tgt != PCTargetE)) begin
                miss_e = 1'b1;
            end
        end
    end

    // Redirect from E outranks any fetch-side prediction.
    always_comb begin
        PCNextF = PCF + STEP;
        if (miss_e) begin
            PCNextF = actual_taken_e ? PCTargetE : (PCE + STEP);
        end else if (pred_taken_f) begin
            PCNextF = btb_tgt_f;
        end
    end

    // Only taken branches teach the BTB a target.
    assign btb_we = resolve_e & ZeroE;

    assign MispredictE = miss_e;
    assign BranchB     = resolve_e;
    assign ZeroB       = ZeroE;
    assign PCB         = PCE;

    // D register: a redirect squashes the wrong-path entry even under stall.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            d_q <= '0;
        end else if (miss_e) begin
            d_q <= '0;
        end else if (!StallD) begin
            d_q <= '{valid: ~StallF, pred_taken: pred_taken_f, pred_tgt: btb_tgt_f};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_q <= '0;
        end else if (FlushE || miss_e) begin
            e_q <= '0;
        end else begin
            e_q <= d_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            BrCount   <= '0;
            MissCount <= '0;
        end else begin
            if (resolve_e && (BrCount != CNT_MAX)) begin
                BrCount <= BrCount + 32'd1;
            end
            if (miss_e && (MissCount != CNT_MAX)) begin
                MissCount <= MissCount + 32'd1;
            end
        end
    end

endmodule
